ysyx_22050133_lsu: RTL and testbench

YSYX_22050133_LSU -- requirements
Module: ysyx_22050133_lsu

---
 rtl/ysyx_22050133_lsu_pkg.sv | 39 +++
 rtl/ysyx_22050133_lsu_if.sv | 36 +++
 rtl/ysyx_22050133_lsu_align.sv | 56 +++++
 rtl/ysyx_22050133_lsu.sv | 134 +++++++++++++
 tb/tb_ysyx_22050133_lsu.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050133_lsu_pkg.sv
// Shared LSU definitions: ctrl_mem field positions,
// access size codes and FSM state constants.
package npcdefine;

  localparam int unsigned CM_LOAD    = 4;
  localparam int unsigned CM_STORE   = 3;
  localparam int unsigned CM_SIZE_HI = 2;
  localparam int unsigned CM_SIZE_LO = 1;
  localparam int unsigned CM_UNS     = 0;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic ok;
    unique case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~off[0];
      2'd2:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_22050133_lsu_if.sv
// Memory bus between the LSU (master) and the
// data memory / bus bridge (slave).
interface ysyx_22050133_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_wmask,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_wmask,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/ysyx_22050133_lsu_align.sv
// Byte-lane steering: store shift/mask and
// load extract with sign/zero extension.
module ysyx_22050133_lsu_align
  import npcdefine::*;
(
  input  mem_size_e   size,
  input  logic [2:0]  off,
  input  logic        uns,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wmask,
  output logic [63:0] ld_data
);

  logic [5:0]  sh;
  logic [63:0] rsh;
  logic [7:0]  base;
  logic        sx;

  assign sh  = {off, 3'b000};
  assign rsh = rdata >> sh;

  always_comb begin
    base = 8'hFF;
    unique case (size)
      SZ_B: base = 8'h01;
      SZ_H: base = 8'h03;
      SZ_W: base = 8'h0F;
      SZ_D: base = 8'hFF;
    endcase
    st_wmask = base << off;
    st_wdata = wdata << sh;
  end

  always_comb begin
    ld_data = rsh;
    sx      = 1'b0;
    unique case (size)
      SZ_B: begin
        sx      = ~uns & rsh[7];
        ld_data = {{56{sx}}, rsh[7:0]};
      end
      SZ_H: begin
        sx      = ~uns & rsh[15];
        ld_data = {{48{sx}}, rsh[15:0]};
      end
      SZ_W: begin
        sx      = ~uns & rsh[31];
        ld_data = {{32{sx}}, rsh[31:0]};
      end
      SZ_D: ld_data = rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050133_lsu.sv
// MEM stage: issues one bus request per load/store,
// passes non-memory results straight through.
module ysyx_22050133_lsu
  import npcdefine::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  ctrl_mem,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  ysyx_22050133_lsu_if.master bus,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [63:0] forward_data_mem,
  output logic        misalign
);

  lsu_state_e  state_q, state_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] res_q, res_d;
  logic        mis_q, mis_d;

  logic        is_mem;
  logic        in_al;
  logic        take;
  logic        pass;
  logic [63:0] st_wdata;
  logic [63:0] ld_data;
  logic [7:0]  st_wmask;

  assign is_mem = ctrl_mem[CM_LOAD] | ctrl_mem[CM_STORE];
  assign in_al  = is_aligned(
    ctrl_mem[CM_SIZE_HI:CM_SIZE_LO], addr[2:0]);
  assign take   = (state_q == ST_IDLE) & in_valid & is_mem;
  // pass-through is combinational, so it must be masked in reset
  assign pass   = (state_q == ST_IDLE) & in_valid
                & ~is_mem & ~rst;

  ysyx_22050133_lsu_align u_align (
    .size     (mem_size_e'(ctrl_q[CM_SIZE_HI:CM_SIZE_LO])),
    .off      (addr_q[2:0]),
    .uns      (ctrl_q[CM_UNS]),
    .wdata    (wdata_q),
    .rdata    (bus.resp_rdata),
    .st_wdata (st_wdata),
    .st_wmask (st_wmask),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take) state_d = in_al ? ST_REQ : ST_DONE;
      ST_REQ:  if (bus.req_ready) state_d = ST_RESP;
      ST_RESP: if (bus.resp_valid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    mis_d   = mis_q;
    if (take) begin
      ctrl_d  = ctrl_mem;
      addr_d  = addr;
      wdata_d = wdata;
      res_d   = '0;
      mis_d   = ~in_al;
    end
    if (state_q == ST_RESP && bus.resp_valid) begin
      res_d = ctrl_q[CM_LOAD] ? ld_data : '0;
    end
  end

  always_comb begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    out_valid     = pass;
    out_data      = pass ? addr : '0;
    misalign      = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        bus.req_valid = 1'b1;
        bus.req_we    = ctrl_q[CM_STORE];
        bus.req_addr  = {addr_q[63:3], 3'b000};
        bus.req_wdata = st_wdata;
        bus.req_wmask = st_wmask;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = res_q;
        misalign  = mis_q;
      end
      default: ;
    endcase
    in_ready         = out_valid;
    forward_data_mem = out_data;
  end

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Randomized scoreboard bench for the LSU with a
// byte-level reference model and a reactive bus slave.
module tb_ysyx_22050133_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  ctrl_mem = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        in_ready;
  logic        out_valid;
  logic        misalign;
  logic [63:0] out_data;
  logic [63:0] fwd;

  ysyx_22050133_lsu_if bus ();

  always #5 clk = ~clk;

  ysyx_22050133_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .ctrl_mem         (ctrl_mem),
    .addr             (addr),
    .wdata            (wdata),
    .bus              (bus),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .forward_data_mem (fwd),
    .misalign         (misalign)
  );

  typedef struct {
    logic [63:0] data;
    logic        mis;
  } out_t;

  typedef struct {
    logic        we;
    logic [63:0] a;
    logic [63:0] w;
    logic [7:0]  m;
  } req_t;

  out_t        exp_out[$];
  req_t        exp_req[$];
  logic [63:0] rd_q[$];

  int n_vec = 0;
  int n_err = 0;
  bit hold_resp = 1'b0;
  bit hs_seen = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [63:0] ref_load(
    input logic [63:0] rd, input int off,
    input int n, input bit uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!uns && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // bus slave: random ready stalls, random response delay,
  // stray resp_valid pulses whenever no response is owed
  initial begin
    int          dly;
    int          stall;
    bit          pend;
    bit          rr;
    logic [63:0] prd;
    dly = 0; stall = 0; pend = 0; prd = '0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.resp_valid = 1'b0;
      if (pend && !hold_resp && !rst) begin
        if (dly == 0) begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = prd;
          pend = 0;
        end else dly--;
      end else if (!pend && ($urandom % 4 == 0)) begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = {$urandom, $urandom};
      end
      if (stall > 0) begin
        rr = 0; stall--;
      end else if ($urandom % 10 == 0) begin
        rr = 0; stall = 4;
      end else rr = 1'($urandom % 2);
      bus.req_ready = rr;
      if (bus.req_valid) begin
        if (exp_req.size() == 0) flag("req_unexpected");
        else begin
          chk("req_we", 64'(bus.req_we), 64'(exp_req[0].we));
          chk("req_addr", bus.req_addr, exp_req[0].a);
          chk("req_wdata", bus.req_wdata, exp_req[0].w);
          chk("req_wmask", 64'(bus.req_wmask),
              64'(exp_req[0].m));
          if (rr) begin
            void'(exp_req.pop_front());
            hs_seen = 1'b1;
            pend = 1;
            dly = $urandom % 3;
            prd = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
          end
        end
      end
    end
  end

  // result monitor
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_out.size() == 0) begin
          $display("FAIL out_unexpected: got %h want none",
                   out_data);
          n_vec++;
          n_err++;
        end else begin
          e = exp_out.pop_front();
          chk("out_data", out_data, e.data);
          chk("fwd_data", fwd, e.data);
          chk("misalign", 64'(misalign), 64'(e.mis));
          chk("in_ready_hi", 64'(in_ready), 64'd1);
        end
      end else begin
        chk("in_ready_lo", 64'(in_ready), 64'd0);
        chk("misalign_lo", 64'(misalign), 64'd0);
      end
    end
  end

  task automatic issue(input logic [4:0]  c,
                       input logic [63:0] a,
                       input logic [63:0] w,
                       input logic [63:0] rd,
                       input bit          track);
    int          n;
    int          off;
    int          cyc;
    bit          mem;
    bit          al;
    logic [63:0] ed;
    req_t        r;
    n   = 1 << c[2:1];
    off = int'(a[2:0]);
    mem = c[4] | c[3];
    al  = (off % n) == 0;
    if (!mem) ed = a;
    else if (!al || c[3]) ed = '0;
    else ed = ref_load(rd, off, n, c[0]);
    if (track) exp_out.push_back('{ed, mem && !al});
    if (mem && al) begin
      r.we = c[3];
      r.a  = a & ~64'h7;
      r.m  = '0;
      r.w  = '0;
      for (int i = 0; i < 8; i++) begin
        if (i >= off && i < off + n) r.m[i] = 1'b1;
        if (i >= off) r.w[8*i +: 8] = w[8*(i-off) +: 8];
      end
      exp_req.push_back(r);
      rd_q.push_back(rd);
    end
    ctrl_mem = c;
    addr     = a;
    wdata    = w;
    in_valid = 1'b1;
    if (track) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (in_ready !== 1'b1 && cyc < 100);
      if (in_ready !== 1'b1) flag("in_ready_timeout");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl_mem = 5'($urandom);
    addr     = {$urandom, $urandom};
    repeat ($urandom % 3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] base;
    logic [4:0]  c;
    logic [2:0]  m;
    logic [63:0] a;
    int          op;
    int          sz;
    int          cyc;
    base = 64'h8000_0000_0000_8000;

    in_valid = 1'b1;
    addr     = 64'h1234;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
    chk("rst_req_we", 64'(bus.req_we), 64'd0);
    chk("rst_req_addr", bus.req_addr, 64'd0);
    chk("rst_req_wdata", bus.req_wdata, 64'd0);
    chk("rst_req_wmask", 64'(bus.req_wmask), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_fwd", fwd, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(5'b00000, 64'h1234, '0, '0, 1);
    issue(5'b10000, base | 64'h3, '0,
          64'h0000_0000_8000_0000, 1);
    issue(5'b10001, base | 64'h3, '0,
          64'h0000_0000_8000_0000, 1);
    issue(5'b01010, base | 64'h6, 64'hABCD, '0, 1);
    issue(5'b10100, base | 64'h2, '0, 64'hFFFF, 1);
    issue(5'b01110, base, 64'h0123_4567_89AB_CDEF, '0, 1);
    issue(5'b10110, base, '0, 64'hFEDC_BA98_7654_3210, 1);
    issue(5'b10010, base | 64'h5, '0, '1, 1);

    for (int k = 0; k < 300; k++) begin
      op = $urandom % 3;
      sz = $urandom % 4;
      c  = {op == 1, op == 2, 2'(sz), 1'($urandom % 2)};
      a  = {$urandom, $urandom};
      if ($urandom % 4 != 0) begin
        m = 3'((1 << sz) - 1);
        a[2:0] = 3'($urandom % 8) & ~m;
      end
      issue(c, a, {$urandom, $urandom},
            {$urandom, $urandom}, 1);
    end

    // abort a load while it waits for its response
    hold_resp = 1'b1;
    hs_seen = 1'b0;
    issue(5'b10110, base | 64'h8, '0, 64'h5555, 0);
    cyc = 0;
    while (!hs_seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (!hs_seen) flag("abort_handshake_timeout");
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    ctrl_mem = 5'b00000;
    addr = 64'h1234;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_req_valid", 64'(bus.req_valid), 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_fwd", fwd, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    hold_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(5'b00000, 64'h1234, '0, '0, 1);
    issue(5'b10000, base | 64'h3, '0,
          64'h0000_0000_8000_0000, 1);

    repeat (5) @(posedge clk);
    chk("exp_out_left", 64'(exp_out.size()), 64'd0);
    chk("exp_req_left", 64'(exp_req.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
